stripe_scheduler: RTL and testbench
===================================

STRIPE_SCHEDULER -- requirements
Module: stripe_scheduler

Interface
REQ-001 SHALL have parameter PAD_BYTE, default 8'hF7: filler byte appended to odd-length packets.
REQ-002 SHALL have parameter MAX_LEN, default 16: maximum packet length in bytes; even, range 2..254.
REQ-003 SHALL have port clk_2f, input, 1: single clock, byte rate of the striper input; all logic on rising edge.
REQ-004 SHALL have port reset, input, 1: reset, synchronous and active-low (0 = reset, sampled on clk_2f rising edge).
REQ-005 SHALL have port req0_valid, input, 1: requester 0 has a byte.
REQ-006 SHALL have port req0_data, input, 8: requester 0 byte.
REQ-007 SHALL have port req0_last, input, 1: byte is the last of its packet.
REQ-008 SHALL have port req0_ready, output, 1: requester 0 byte accepted this cycle when high with req0_valid.
REQ-009 SHALL have ports req1_valid, req1_data, req1_last and req1_ready, with widths 1, 8, 1 and 1, identical in meaning to the requester 0 ports.
REQ-010 SHALL have port valid_in, output, 1: byte valid toward the byte striper.
REQ-011 SHALL have port data_in, output, 8: byte toward the byte striper.
REQ-012 SHALL have port grant, output, 2: one-hot owner of the current packet; bit0 = req0, 00 = none.
REQ-013 SHALL have port err_trunc, output, 1: one-cycle pulse when a packet is force-terminated at MAX_LEN.

Function
REQ-014 SHALL implement the FSM states IDLE, SEND, PAD and GAP, plus a registered round-robin pointer rr (0 = req0 preferred).
REQ-015 SHALL, in IDLE with any reqN_valid=1, set grant to the winner and go to SEND; otherwise it SHALL stay in IDLE with grant=00.
REQ-016 SHALL, when both requesters are valid in IDLE, grant the requester indicated by rr; with one valid, it SHALL grant that one regardless of rr.
REQ-017 SHALL set rr to point at the non-granted requester when the grant is issued.
REQ-018 SHALL drive reqN_ready=1 only in SEND and only for the granted N; the ready SHALL depend on registered state only, never on reqN_valid.
REQ-019 SHALL make a transfer when valid and ready are both high; on the next edge it SHALL set data_in to the byte, set valid_in=1, and increment the 8-bit byte count cnt.
REQ-020 SHALL have a latency of exactly 1 clk_2f cycle from an accepted byte to valid_in/data_in.
REQ-021 SHALL, in SEND with the granted valid low, set valid_in=0 on the next edge (a bubble) and stay in SEND.
REQ-022 SHALL, on a transfer with last=1, go to PAD if the new cnt is odd and to GAP if it is even.
REQ-023 SHALL, on a transfer with last=0 where the new cnt equals MAX_LEN, end the packet: go to GAP and pulse err_trunc=1 for one cycle.
REQ-024 SHALL treat a transfer with last=1 where the new cnt equals MAX_LEN as a normal last, with no err_trunc.
REQ-025 SHALL, in PAD, set data_in=PAD_BYTE and valid_in=1 for one cycle, then go to GAP.
REQ-026 SHALL, in GAP, set valid_in=0 for one cycle, clear cnt and grant, then go to IDLE.
REQ-027 SHALL keep every packet sent to the striper at even length, so lane_0 and lane_1 receive equal byte counts.
REQ-028 SHALL treat bytes remaining after truncation as a new packet from the same requester, arbitrated normally.
REQ-029 SHALL hold data_in at its last value whenever valid_in=0.

Reset
REQ-030 SHALL, while reset=0 at a clk_2f edge, set state=IDLE, rr=0, cnt=0, grant=00, valid_in=0, data_in=8'h00, err_trunc=0, req0_ready=0 and req1_ready=0.
REQ-031 SHALL, when reset is asserted mid-packet, abort the packet immediately with no PAD and no err_trunc, and start from IDLE after release.

Verification
REQ-032 SHALL be verified by: req0 sends a 4-byte packet AA,BB,CC,DD with last on DD -> valid_in run AA,BB,CC,DD one cycle after each accept, then one GAP cycle, no pad.
REQ-033 SHALL be verified by: req1 sends a 3-byte packet 11,22,33 -> data_in run 11,22,33,F7, then GAP; lane byte counts equal (2/2).
REQ-034 SHALL be verified by: both requesters continuously valid from reset -> grants alternate 01,10,01,...; first grant = 01.
REQ-035 SHALL be verified by: req0 sends 20 bytes with no last -> first 16 bytes pass, err_trunc pulses once, and the remaining 4 bytes arrive as a new packet after req1 is served (if req1 valid).
REQ-036 SHALL be verified by: reset=0 after byte 2 of a packet -> all outputs 0 next cycle, no F7, and after release arbitration restarts with rr=0.
REQ-037 SHALL be verified by: req0_valid toggled 1,0,1 mid-packet -> valid_in shows a bubble and order is preserved.

Source files
------------

// File: rtl/stripe_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : stripe_scheduler
//  Description : Two-requester round-robin packet scheduler feeding a byte
//                striper. Pads odd-length packets with PAD_BYTE so both
//                striper lanes always receive equal byte counts, and
//                force-terminates packets that reach MAX_LEN bytes.
//  Revision    : 1.0 - initial release
// ============================================================================
module stripe_scheduler #(
    parameter logic [7:0] PAD_BYTE = 8'hF7,
    parameter int         MAX_LEN  = 16
) (
    input  logic       clk_2f,
    input  logic       reset,
    input  logic       req0_valid,
    input  logic [7:0] req0_data,
    input  logic       req0_last,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [7:0] req1_data,
    input  logic       req1_last,
    output logic       req1_ready,
    output logic       valid_in,
    output logic [7:0] data_in,
    output logic [1:0] grant,
    output logic       err_trunc
);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_SEND = 2'd1;
    localparam logic [1:0] c_ST_PAD  = 2'd2;
    localparam logic [1:0] c_ST_GAP  = 2'd3;

    localparam logic [7:0] c_MAX_CNT = 8'(MAX_LEN);

    logic [1:0] r_state;
    logic       r_rr;
    logic [7:0] r_cnt;

    logic       w_take0;
    logic       w_take1;
    logic       w_xfer;
    logic [7:0] w_byte;
    logic       w_last;
    logic [7:0] w_cnt_next;
    logic       w_pick1;

    // Ready comes only from registered state so it never loops back through valid
    assign req0_ready = (r_state == c_ST_SEND) && grant[0];
    assign req1_ready = (r_state == c_ST_SEND) && grant[1];

    assign w_take0    = req0_valid && req0_ready;
    assign w_take1    = req1_valid && req1_ready;
    assign w_xfer     = w_take0 || w_take1;
    assign w_byte     = grant[1] ? req1_data : req0_data;
    assign w_last     = grant[1] ? req1_last : req0_last;
    assign w_cnt_next = r_cnt + 8'd1;

    // Requester 1 wins when it is the only one asking, or when both ask and rr favours it
    assign w_pick1    = req1_valid && (!req0_valid || r_rr);

    // Packet sequencing: arbitrate, forward bytes, pad to even length, one idle gap
    always_ff @(posedge clk_2f) begin
        if (!reset) begin
            r_state   <= c_ST_IDLE;
            r_rr      <= 1'b0;
            r_cnt     <= 8'd0;
            grant     <= 2'b00;
            valid_in  <= 1'b0;
            data_in   <= 8'h00;
            err_trunc <= 1'b0;
        end else begin
            err_trunc <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    valid_in <= 1'b0;
                    if (req0_valid || req1_valid) begin
                        grant   <= w_pick1 ? 2'b10 : 2'b01;
                        r_rr    <= !w_pick1;
                        r_state <= c_ST_SEND;
                    end
                end
                c_ST_SEND: begin
                    if (w_xfer) begin
                        data_in  <= w_byte;
                        valid_in <= 1'b1;
                        r_cnt    <= w_cnt_next;
                        if (w_last) begin
                            // Odd-length packets get one filler byte to keep lanes balanced
                            r_state <= w_cnt_next[0] ? c_ST_PAD : c_ST_GAP;
                        end else if (w_cnt_next == c_MAX_CNT) begin
                            r_state   <= c_ST_GAP;
                            err_trunc <= 1'b1;
                        end
                    end else begin
                        valid_in <= 1'b0;
                    end
                end
                c_ST_PAD: begin
                    data_in  <= PAD_BYTE;
                    valid_in <= 1'b1;
                    r_state  <= c_ST_GAP;
                end
                c_ST_GAP: begin
                    valid_in <= 1'b0;
                    r_cnt    <= 8'd0;
                    grant    <= 2'b00;
                    r_state  <= c_ST_IDLE;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_stripe_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_stripe_scheduler
//  Description : Directed self-checking bench for stripe_scheduler. Requester
//                byte queues drive the DUT; every cycle's outputs are logged
//                and compared against hand-computed sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_stripe_scheduler;

    logic       clk_2f = 1'b0;
    logic       reset;
    logic       req0_valid, req0_last, req0_ready;
    logic [7:0] req0_data;
    logic       req1_valid, req1_last, req1_ready;
    logic [7:0] req1_data;
    logic       valid_in;
    logic [7:0] data_in;
    logic [1:0] grant;
    logic       err_trunc;

    int n_checks = 0;
    int n_fail   = 0;

    // Requester queues: {last, data}
    logic [8:0] q0[$];
    logic [8:0] q1[$];
    logic       stall0 = 1'b0;

    // Per-cycle output log for the current scenario
    logic       tv[64];
    logic [7:0] td[64];
    logic [1:0] tg[64];
    logic       te[64];
    int         n = 0;

    logic [7:0] exp_q[$];
    logic [1:0] exp_g[$];

    stripe_scheduler #(
        .PAD_BYTE (8'hF7),
        .MAX_LEN  (16)
    ) dut (
        .clk_2f     (clk_2f),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_data  (req0_data),
        .req0_last  (req0_last),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_data  (req1_data),
        .req1_last  (req1_last),
        .req1_ready (req1_ready),
        .valid_in   (valid_in),
        .data_in    (data_in),
        .grant      (grant),
        .err_trunc  (err_trunc)
    );

    always #5 clk_2f = ~clk_2f;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: present queue heads, note handshakes before the edge, log outputs after it
    task automatic tick();
        logic a0, a1;
        req0_valid = (q0.size() > 0) && !stall0;
        req0_data  = (q0.size() > 0) ? q0[0][7:0] : 8'h00;
        req0_last  = (q0.size() > 0) ? q0[0][8]   : 1'b0;
        req1_valid = (q1.size() > 0);
        req1_data  = (q1.size() > 0) ? q1[0][7:0] : 8'h00;
        req1_last  = (q1.size() > 0) ? q1[0][8]   : 1'b0;
        @(negedge clk_2f);
        a0 = req0_valid && req0_ready;
        a1 = req1_valid && req1_ready;
        @(posedge clk_2f);
        #1;
        if (a0) void'(q0.pop_front());
        if (a1) void'(q1.pop_front());
        if (n < 64) begin
            tv[n] = valid_in;
            td[n] = data_in;
            tg[n] = grant;
            te[n] = err_trunc;
            n++;
        end
    endtask

    task automatic check_stream(input string tag);
        logic [7:0] obs[$];
        for (int i = 0; i < n; i++) if (tv[i]) obs.push_back(td[i]);
        check_eq({tag, "_len"}, obs.size(), exp_q.size());
        for (int i = 0; i < obs.size() && i < exp_q.size(); i++)
            check_eq($sformatf("%s_b%0d", tag, i), obs[i], exp_q[i]);
    endtask

    task automatic check_grants(input string tag);
        logic [1:0] obs[$];
        logic [1:0] prev = 2'b00;
        for (int i = 0; i < n; i++) begin
            if (tg[i] != 2'b00 && prev == 2'b00) obs.push_back(tg[i]);
            prev = tg[i];
        end
        check_eq({tag, "_cnt"}, obs.size(), exp_g.size());
        for (int i = 0; i < obs.size() && i < exp_g.size(); i++)
            check_eq($sformatf("%s_g%0d", tag, i), obs[i], exp_g[i]);
    endtask

    function automatic int count_err();
        int c = 0;
        for (int i = 0; i < n; i++) if (te[i]) c++;
        return c;
    endfunction

    task automatic apply_reset();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        n = 0;
    endtask

    initial begin
        int lane0, lane1, cnt;
        reset = 1'b0;
        req0_valid = 1'b0; req0_data = 8'h00; req0_last = 1'b0;
        req1_valid = 1'b0; req1_data = 8'h00; req1_last = 1'b0;

        // Reset state
        tick();
        tick();
        check_eq("rst_valid_in", valid_in, 1'b0);
        check_eq("rst_data_in", data_in, 8'h00);
        check_eq("rst_grant", grant, 2'b00);
        check_eq("rst_err", err_trunc, 1'b0);
        check_eq("rst_ready0", req0_ready, 1'b0);
        check_eq("rst_ready1", req1_ready, 1'b0);
        reset = 1'b1;

        // Even packet from req0: no pad, one gap
        n = 0;
        q0 = {9'h0AA, 9'h0BB, 9'h0CC, 9'h1DD};
        repeat (8) tick();
        check_eq("a_grant_cyc_valid", tv[0], 1'b0);
        check_eq("a_grant", tg[0], 2'b01);
        check_eq("a_first_byte", {tv[1], td[1]}, {1'b1, 8'hAA});
        check_eq("a_last_byte", {tv[4], td[4]}, {1'b1, 8'hDD});
        check_eq("a_gap_valid", tv[5], 1'b0);
        check_eq("a_gap_hold", td[5], 8'hDD);
        check_eq("a_gap_grant", tg[5], 2'b00);
        exp_q = {8'hAA, 8'hBB, 8'hCC, 8'hDD};
        check_stream("a_stream");

        // Odd packet from req1: padded with F7
        n = 0;
        q1 = {9'h011, 9'h022, 9'h133};
        repeat (8) tick();
        check_eq("b_grant", tg[0], 2'b10);
        check_eq("b_pad", {tv[4], td[4]}, {1'b1, 8'hF7});
        check_eq("b_gap_valid", tv[5], 1'b0);
        exp_q = {8'h11, 8'h22, 8'h33, 8'hF7};
        check_stream("b_stream");
        cnt = 0;
        for (int i = 0; i < n; i++) if (tv[i]) cnt++;
        lane0 = (cnt + 1) / 2;
        lane1 = cnt / 2;
        check_eq("b_lane0", lane0, 2);
        check_eq("b_lane1", lane1, 2);

        // Both requesters valid from reset: grants alternate starting with req0
        q0 = {9'h001, 9'h102, 9'h001, 9'h102};
        q1 = {9'h081, 9'h182, 9'h081, 9'h182};
        apply_reset();
        repeat (24) tick();
        exp_g = {2'b01, 2'b10, 2'b01, 2'b10};
        check_grants("c_grants");
        exp_q = {8'h01, 8'h02, 8'h81, 8'h82, 8'h01, 8'h02, 8'h81, 8'h82};
        check_stream("c_stream");

        // Truncation at MAX_LEN; tail of 4 bytes (last on the 20th) follows req1's packet
        apply_reset();
        for (int i = 1; i <= 20; i++) q0.push_back({(i == 20), 8'(i)});
        q1 = {9'h0E1, 9'h1E2};
        repeat (40) tick();
        check_eq("d_err_count", count_err(), 1);
        check_eq("d_err_on_16th", {te[16], tv[16], td[16]}, {1'b1, 1'b1, 8'h10});
        exp_g = {2'b01, 2'b10, 2'b01};
        check_grants("d_grants");
        exp_q.delete();
        for (int i = 1; i <= 16; i++) exp_q.push_back(8'(i));
        exp_q.push_back(8'hE1);
        exp_q.push_back(8'hE2);
        for (int i = 17; i <= 20; i++) exp_q.push_back(8'(i));
        check_stream("d_stream");

        // last exactly at MAX_LEN: ordinary end, no error, no pad
        n = 0;
        exp_q.delete();
        for (int i = 0; i < 16; i++) begin
            q0.push_back({(i == 15), 8'(8'hC0 + i)});
            exp_q.push_back(8'(8'hC0 + i));
        end
        repeat (20) tick();
        check_eq("d2_err_count", count_err(), 0);
        check_stream("d2_stream");

        // Reset mid-packet after the second byte of an odd packet
        n = 0;
        q0 = {9'h0A0, 9'h0A1, 9'h1A2};
        repeat (3) tick();
        check_eq("e_second_byte", {tv[2], td[2]}, {1'b1, 8'hA1});
        reset = 1'b0;
        tick();
        check_eq("e_rst_outs", {valid_in, data_in, grant, err_trunc}, 12'h000);
        check_eq("e_rst_ready", {req0_ready, req1_ready}, 2'b00);
        q0.delete();
        tick();
        check_eq("e_no_pad", {valid_in, data_in}, 9'h000);
        reset = 1'b1;
        n = 0;
        q0 = {9'h051, 9'h152};
        q1 = {9'h061, 9'h162};
        repeat (12) tick();
        exp_g = {2'b01, 2'b10};
        check_grants("e_restart");
        exp_q = {8'h51, 8'h52, 8'h61, 8'h62};
        check_stream("e_stream");

        // Valid toggled mid-packet: bubble with held data, order preserved
        n = 0;
        q0 = {9'h031, 9'h032, 9'h133};
        tick();
        tick();
        stall0 = 1'b1;
        tick();
        stall0 = 1'b0;
        repeat (6) tick();
        check_eq("f_bubble", {tv[2], td[2]}, {1'b0, 8'h31});
        exp_q = {8'h31, 8'h32, 8'h33, 8'hF7};
        check_stream("f_stream");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
